// File: rtl/jtframe_pocket_pkg.sv
// Shared constants and types for the Analogue Pocket audio path.
// Includes the slot-mux helper used by the I2S serializer.
package jtframe_pocket_pkg;

  localparam int I2S_SLOTS = 32;
  localparam int SND_W     = 16;
  localparam int SCLK_DIV  = 4;

  typedef logic [4:0] slot_t;

  typedef struct packed {
    logic [SND_W-1:0] l;
    logic [SND_W-1:0] r;
  } stereo_t;

  // Slot 0 is the I2S one-bit delay; slots 1..16 carry the word MSB first.
  function automatic logic slot_bit(input slot_t k, input logic [SND_W-1:0] w);
    logic [3:0] idx;
    idx = 4'(5'(SND_W) - k);
    if (k == '0 || k > slot_t'(SND_W)) return 1'b0;
    return w[idx];
  endfunction

endpackage

// File: rtl/jtframe_pocket_i2s_ser.sv
// I2S serializer: bit-clock divider, slot counter, transmit registers
// and the registered data output. Runs entirely on the audio master clock.
module jtframe_pocket_i2s_ser
  import jtframe_pocket_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SND_W-1:0] hold_l,
  input  logic [SND_W-1:0] hold_r,
  input  logic             pend,
  output logic             load,
  output logic             audio_sclk,
  output logic             audio_lrck,
  output logic             audio_dac
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam int CNT_W = $clog2(2 * I2S_SLOTS);

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] bitcnt;
  logic [CNT_W-1:0] bitcnt_nx;
  logic             sclk_end;
  stereo_t          tx;

  assign sclk_end   = div == DIV_W'(SCLK_DIV - 1);
  assign bitcnt_nx  = bitcnt + CNT_W'(1);
  assign load       = sclk_end && (&bitcnt);
  assign audio_sclk = div[DIV_W-1];
  assign audio_lrck = bitcnt[CNT_W-1];

  // Data moves on the SCLK falling edge, using the slot index about to start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      bitcnt    <= '0;
      tx        <= '0;
      audio_dac <= 1'b0;
    end else begin
      div <= div + DIV_W'(1);
      if (sclk_end) begin
        bitcnt    <= bitcnt_nx;
        audio_dac <= slot_bit(slot_t'(bitcnt_nx[CNT_W-2:0]),
                              bitcnt_nx[CNT_W-1] ? tx.r : tx.l);
      end
      // Underflow leaves tx untouched so the last sample repeats.
      if (load && pend) begin
        tx.l <= hold_l;
        tx.r <= hold_r;
      end
    end
  end

endmodule

// File: rtl/jtframe_pocket_i2s.sv
// Pocket audio DAC driver: samples cross in from the core domain via a toggle
// strobe, are double buffered and serialized as 48 kHz I2S. Optional feature
// macro JTFRAME_POCKET_MONO_EN mixes L and R into a mono signal at capture.
module jtframe_pocket_i2s
  import jtframe_pocket_pkg::*;
#(
  parameter logic SIGNED_SND = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SND_W-1:0] snd_left,
  input  logic [SND_W-1:0] snd_right,
  input  logic             snd_sample,
  output logic             audio_sclk,
  output logic             audio_lrck,
  output logic             audio_dac,
  output logic             snd_drop
);

  logic [2:0]       sync;
  logic             edge_det;
  logic             capture;
  logic             load;
  logic             pend;
  logic [SND_W-1:0] hold_l;
  logic [SND_W-1:0] hold_r;
  logic [SND_W-1:0] cv_l;
  logic [SND_W-1:0] cv_r;
  logic [SND_W-1:0] new_l;
  logic [SND_W-1:0] new_r;

  // sync[1:0] is the synchronizer, sync[2] the previous value for edge detect.
  assign edge_det = sync[1] ^ sync[2];

  assign cv_l = SIGNED_SND ? snd_left  : {~snd_left[SND_W-1],  snd_left[SND_W-2:0]};
  assign cv_r = SIGNED_SND ? snd_right : {~snd_right[SND_W-1], snd_right[SND_W-2:0]};

`ifdef JTFRAME_POCKET_MONO_EN
  logic [SND_W:0] mix_sum;
  // 17-bit sum cannot overflow; dropping the LSB is the arithmetic shift.
  assign mix_sum = {cv_l[SND_W-1], cv_l} + {cv_r[SND_W-1], cv_r};
  assign new_l   = mix_sum[SND_W:1];
  assign new_r   = mix_sum[SND_W:1];
`else
  assign new_l = cv_l;
  assign new_r = cv_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      capture  <= 1'b0;
      hold_l   <= '0;
      hold_r   <= '0;
      pend     <= 1'b0;
      snd_drop <= 1'b0;
    end else begin
      sync    <= {sync[1:0], snd_sample};
      capture <= edge_det;
      if (capture) begin
        hold_l <= new_l;
        hold_r <= new_r;
      end
      // A capture coinciding with a frame load keeps the new sample pending.
      if (capture)   pend <= 1'b1;
      else if (load) pend <= 1'b0;
      snd_drop <= capture & pend & ~load;
    end
  end

  jtframe_pocket_i2s_ser u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold_l     (hold_l),
    .hold_r     (hold_r),
    .pend       (pend),
    .load       (load),
    .audio_sclk (audio_sclk),
    .audio_lrck (audio_lrck),
    .audio_dac  (audio_dac)
  );

endmodule

// File: tb/tb_jtframe_pocket_i2s.sv
// Bench for jtframe_pocket_i2s: a signed and an offset-binary instance share
// stimulus; a sample-level model predicts frame contents, drops and clocks.
module tb_jtframe_pocket_i2s;

  logic        clk;
  logic        rst_n;
  logic [15:0] snd_left;
  logic [15:0] snd_right;
  logic        snd_sample;
  logic        sclk_s, lrck_s, dac_s, drop_s;
  logic        sclk_u, lrck_u, dac_u, drop_u;

  jtframe_pocket_i2s #(.SIGNED_SND(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .snd_left(snd_left), .snd_right(snd_right),
    .snd_sample(snd_sample), .audio_sclk(sclk_s), .audio_lrck(lrck_s),
    .audio_dac(dac_s), .snd_drop(drop_s)
  );

  jtframe_pocket_i2s #(.SIGNED_SND(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .snd_left(snd_left), .snd_right(snd_right),
    .snd_sample(snd_sample), .audio_sclk(sclk_u), .audio_lrck(lrck_u),
    .audio_dac(dac_u), .snd_drop(drop_u)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_vec;
  int          n_err;
  int          e;                 // clk edges since reset release
  logic [63:0] exp_q[$];          // expected {sL,sR,uL,uR} per frame
  int          cap_edge_q[$];
  logic [63:0] cap_word_q[$];
  logic [63:0] m_hold;
  logic [63:0] m_tx;
  bit          m_pend;
  bit          exp_drop;
  logic [15:0] acc_l[2];
  logic [15:0] acc_r[2];
  logic        acc_z[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, e, got, exp);
    end
  endtask

  // Word the DAC should see for a given input pair and sample format.
  function automatic logic [31:0] model_word(input logic [15:0] l, input logic [15:0] r,
                                             input bit sgn);
    logic [15:0] ul;
    logic [15:0] ur;
    int          sl;
    int          sr;
    int          m;
    ul = sgn ? l : (l ^ 16'h8000);
    ur = sgn ? r : (r ^ 16'h8000);
    sl = $signed(ul);
    sr = $signed(ur);
`ifdef JTFRAME_POCKET_MONO_EN
    m = (sl + sr) >>> 1;
    return {m[15:0], m[15:0]};
`else
    m = sl + sr;
    return {ul, ur};
`endif
  endfunction

  task automatic clear_acc();
    for (int d = 0; d < 2; d++) begin
      acc_l[d] = '0;
      acc_r[d] = '0;
      acc_z[d] = 1'b0;
    end
  endtask

  // One clk edge of the sample-level model: frame loads every 256 edges,
  // captures 4 edges after a strobe toggle.
  task automatic model_step();
    bit pb;
    bit is_load;
    bit is_cap;
    pb      = m_pend;
    is_load = (e % 256) == 0;
    is_cap  = cap_edge_q.size() > 0 && cap_edge_q[0] == e;
    if (is_load && pb) begin
      m_tx   = m_hold;
      m_pend = 1'b0;
    end
    if (is_load) exp_q.push_back(m_tx);
    exp_drop = is_cap && pb && !is_load;
    if (is_cap) begin
      m_hold = cap_word_q.pop_front();
      void'(cap_edge_q.pop_front());
      m_pend = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic        o_sclk[2];
    logic        o_lrck[2];
    logic        o_dac[2];
    logic        o_drop[2];
    logic [63:0] fr;
    logic [31:0] w;
    int          b;
    int          k;
    o_sclk = '{sclk_s, sclk_u};
    o_lrck = '{lrck_s, lrck_u};
    o_dac  = '{dac_s, dac_u};
    o_drop = '{drop_s, drop_u};
    b = (e / 4) % 64;
    k = b % 32;
    for (int d = 0; d < 2; d++) begin
      check(d == 0 ? "sclk_s" : "sclk_u", 64'(o_sclk[d]), 64'((e % 4) >= 2));
      check(d == 0 ? "lrck_s" : "lrck_u", 64'(o_lrck[d]), 64'((e / 128) % 2));
      check(d == 0 ? "drop_s" : "drop_u", 64'(o_drop[d]), 64'(exp_drop));
      if (e % 4 == 2) begin
        if (k >= 1 && k <= 16) begin
          if (b >= 32) acc_r[d][16-k] = o_dac[d];
          else         acc_l[d][16-k] = o_dac[d];
        end else begin
          acc_z[d] = acc_z[d] | o_dac[d];
        end
      end
    end
    if (e % 4 == 2 && b == 63) begin
      if (exp_q.size() == 0) begin
        check("frame_q", 64'(0), 64'(1));
      end else begin
        fr = exp_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          w = (d == 0) ? fr[63:32] : fr[31:0];
          check(d == 0 ? "left_s"  : "left_u",  64'(acc_l[d]), 64'(w[31:16]));
          check(d == 0 ? "right_s" : "right_u", 64'(acc_r[d]), 64'(w[15:0]));
          check(d == 0 ? "zeros_s" : "zeros_u", 64'(acc_z[d]), 64'(0));
        end
      end
      clear_acc();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check("rst_sclk", 64'({sclk_s, sclk_u}), 64'(0));
      check("rst_lrck", 64'({lrck_s, lrck_u}), 64'(0));
      check("rst_dac",  64'({dac_s, dac_u}),   64'(0));
      check("rst_drop", 64'({drop_s, drop_u}), 64'(0));
    end else begin
      e++;
      model_step();
      check_outputs();
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n    = 1'b1;
    e        = 0;
    m_tx     = '0;
    m_hold   = '0;
    m_pend   = 1'b0;
    exp_drop = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
    cap_edge_q.delete();
    cap_word_q.delete();
    clear_acc();
    // A strobe left high looks like a toggle to the freshly cleared synchronizer.
    if (snd_sample) begin
      cap_edge_q.push_back(4);
      cap_word_q.push_back({model_word(snd_left, snd_right, 1'b1),
                            model_word(snd_left, snd_right, 1'b0)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    snd_left   = l;
    snd_right  = r;
    snd_sample = ~snd_sample;
    cap_edge_q.push_back(e + 4);
    cap_word_q.push_back({model_word(l, r, 1'b1), model_word(l, r, 1'b0)});
  endtask

  task automatic wait_edges(input int n);
    repeat (n) tick();
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < 256 && (e % 256) != phase; i++) tick();
  endtask

  logic [31:0] dir_tab[6];

  initial begin
    n_vec      = 0;
    n_err      = 0;
    e          = 0;
    snd_left   = '0;
    snd_right  = '0;
    snd_sample = 1'b0;
    dir_tab    = '{32'h8001_7FFE, 32'h0000_0000, 32'h7FFF_7FFF,
                   32'h8000_7FFF, 32'hFFFF_0001, 32'h1234_ABCD};

    do_reset(10);
    wait_edges(300);

    foreach (dir_tab[i]) begin
      send(dir_tab[i][31:16], dir_tab[i][15:0]);
      wait_edges(600);
    end

    // Overrun: two samples 20 clk apart inside one frame.
    align(20);
    send(16'hA5A5, 16'h5A5A);
    wait_edges(20);
    send(16'h0F0F, 16'hF0F0);
    wait_edges(600);

    // Underflow: one sample repeated over several frames.
    send(16'h1234, 16'h1234);
    wait_edges(4 * 256);

    // Capture lands on the frame-load edge, then another sample overruns it.
    align(252);
    send(16'hC0DE, 16'hBEEF);
    wait_edges(20);
    send(16'h4321, 16'h8765);
    wait_edges(600);

    for (int i = 0; i < 50; i++) begin
      send(16'($urandom), 16'($urandom));
      wait_edges($urandom_range(8, 600));
    end

    // Reset mid-frame, possibly with the strobe left high.
    align(100);
    do_reset(5);
    wait_edges(600);

    for (int i = 0; i < 20; i++) begin
      send(16'($urandom), 16'($urandom));
      wait_edges($urandom_range(8, 400));
    end
    wait_edges(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
